// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC data-memory responder.
//   - default data / word-address widths
//   - responder FSM state encoding
//   - access-kind codes, numerically equal to the LOD/STR/SWP opcodes
//   - acc_kind(): decodes the we/swp request flags into an access kind
package sisc_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACC_LOD = 2'd1,
        ACC_STR = 2'd2,
        ACC_SWP = 2'd3
    } acc_t;

    // swp outranks we, so swp=1/we=1 is still a swap.
    function automatic acc_t acc_kind(input logic we, input logic swp);
        if (swp)
            return ACC_SWP;
        else if (we)
            return ACC_STR;
        else
            return ACC_LOD;
    endfunction

endpackage

// File: rtl/sisc_dmem_array.sv
// sisc_dmem_array: single-port synchronous RAM, read-before-write.
// Kept as its own module so a vendor macro can replace it.
// Ports:
//   clk    in   rising-edge clock
//   en     in   access enable; nothing happens when low
//   we     in   write enable (qualified by en)
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  word at idx before any write of the same edge
module sisc_dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; contents survive rst_f.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we)
                mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/sisc_dmem_resp.sv
// sisc_dmem_resp: data-memory responder for the SISC datapath.
// Serves load/store/swap with a 4-phase req/ack handshake, inserts LAT
// wait cycles between acceptance and commit, and flags out-of-range
// addresses with err.
// Ports:
//   clk    in   rising-edge clock
//   rst_f  in   synchronous active-low reset
//   req    in   request level, held until ack, then dropped
//   we     in   1 = store (sampled at acceptance)
//   swp    in   1 = swap, overrides we (sampled at acceptance)
//   addr   in   word address (sampled at acceptance)
//   wdata  in   store/swap data (sampled at acceptance)
//   ack    out  access complete, held until req drops
//   rdata  out  load data / old swap word, valid while ack
//   err    out  address >= DEPTH, valid while ack
//   busy   out  not idle
module sisc_dmem_resp
    import sisc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic              we,
    input  logic              swp,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state, nstate;
    logic [3:0]        cnt;
    acc_t              acc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              commit;

    // With LAT=0 the commit shares the acceptance edge, so the RAM must be
    // fed from the live inputs while idle and from the latches afterwards.
    logic              idle;
    acc_t              acc_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              in_range;
    logic [DATA_W-1:0] ram_q;

    assign idle      = (state == ST_IDLE);
    assign acc_sel   = idle ? acc_kind(we, swp) : acc_q;
    assign addr_sel  = idle ? addr : addr_q;
    assign wdata_sel = idle ? wdata : wdata_q;
    assign in_range  = ({1'b0, addr_sel} < DEPTH_L);

    always_comb begin
        nstate = state;
        commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (LAT == 0) begin
                        commit = 1'b1;
                        nstate = ST_DONE;
                    end else begin
                        nstate = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    commit = 1'b1;
                    nstate = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req)
                    nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            acc_q   <= ACC_LOD;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= nstate;
            if (idle && req) begin
                acc_q   <= acc_kind(we, swp);
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CNT_INIT;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit)
                err_q <= !in_range;
            else if (state == ST_DONE && !req)
                err_q <= 1'b0;
        end
    end

    // Reset wins over a pending commit, so an aborted access never writes.
    sisc_dmem_array #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (commit && in_range && rst_f),
        .we    (acc_sel != ACC_LOD),
        .idx   (addr_sel[IDX_W-1:0]),
        .wdata (wdata_sel),
        .rdata (ram_q)
    );

    // RAM output is only meaningful in DONE after an in-range load/swap;
    // everything else reads as zero, which also covers reset and release.
    assign ack   = (state == ST_DONE);
    assign busy  = !idle;
    assign err   = ack && err_q;
    assign rdata = (ack && !err_q && acc_q != ACC_STR) ? ram_q : '0;

endmodule

// File: tb/tb_sisc_dmem_resp.sv
// Randomized self-checking bench for sisc_dmem_resp.
// dut_a: LAT=2, DEPTH=128 (out-of-range reachable); dut_b: LAT=0, DEPTH=256.
module tb_sisc_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, we_a, swp_a, ack_a, err_a, busy_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a, rdata_a;
    logic        rst_b, req_b, we_b, swp_b, ack_b, err_b, busy_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b, rdata_b;

    sisc_dmem_resp #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .LAT(2)) dut_a (
        .clk(clk), .rst_f(rst_a), .req(req_a), .we(we_a), .swp(swp_a),
        .addr(addr_a), .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a),
        .err(err_a), .busy(busy_a)
    );

    sisc_dmem_resp #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LAT(0)) dut_b (
        .clk(clk), .rst_f(rst_b), .req(req_b), .we(we_b), .swp(swp_b),
        .addr(addr_b), .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b),
        .err(err_b), .busy(busy_b)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference memory image per DUT, indexed [sel][addr].
    logic [31:0] mem_m [2][256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive(input int sel, input logic r, input logic w, input logic s,
                         input logic [7:0] a, input logic [31:0] d);
        if (sel == 0) begin
            req_a = r; we_a = w; swp_a = s; addr_a = a; wdata_a = d;
        end else begin
            req_b = r; we_b = w; swp_b = s; addr_b = a; wdata_b = d;
        end
    endtask

    function automatic logic o_ack(input int sel);
        return (sel == 0) ? ack_a : ack_b;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic o_err(input int sel);
        return (sel == 0) ? err_a : err_b;
    endfunction
    function automatic logic [31:0] o_rdata(input int sel);
        return (sel == 0) ? rdata_a : rdata_b;
    endfunction

    // One full handshake. Inputs are scrambled right after acceptance to
    // prove they were latched; ack must arrive exactly LAT edges later.
    task automatic access(input int sel, input logic w, input logic s,
                          input logic [7:0] a, input logic [31:0] d,
                          input bit drop_early, input int hold);
        int unsigned lat   = (sel == 0) ? 2 : 0;
        int unsigned depth = (sel == 0) ? 128 : 256;
        logic [31:0] exp_rd;
        logic        exp_err;
        int unsigned n;
        bit          early;

        if (a < depth) begin
            exp_err = 1'b0;
            if (s) begin
                exp_rd = mem_m[sel][a];
                mem_m[sel][a] = d;
            end else if (w) begin
                exp_rd = '0;
                mem_m[sel][a] = d;
            end else begin
                exp_rd = mem_m[sel][a];
            end
        end else begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end

        early = drop_early && (lat > 0);
        @(negedge clk);
        drive(sel, 1'b1, w, s, a, d);
        @(posedge clk); #1;
        chk("busy_after_accept", {31'd0, o_busy(sel)}, 32'd1);
        drive(sel, !early, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
        n = 0;
        while (!o_ack(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_latency", n, lat);
        chk("rdata", o_rdata(sel), exp_rd);
        chk("err", {31'd0, o_err(sel)}, {31'd0, exp_err});
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_ack", {31'd0, o_ack(sel)}, 32'd1);
                chk("hold_rdata", o_rdata(sel), exp_rd);
            end
        end
        @(negedge clk);
        drive(sel, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), $urandom);
        @(posedge clk); #1;
        chk("release_ack", {31'd0, o_ack(sel)}, 32'd0);
        chk("release_busy", {31'd0, o_busy(sel)}, 32'd0);
        chk("release_rdata", o_rdata(sel), 32'd0);
        chk("release_err", {31'd0, o_err(sel)}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_ack",   {31'd0, o_ack(s)},  32'd0);
            chk("reset_busy",  {31'd0, o_busy(s)}, 32'd0);
            chk("reset_err",   {31'd0, o_err(s)},  32'd0);
            chk("reset_rdata", o_rdata(s), 32'd0);
        end
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // Fill every implemented word so the model is fully known.
        for (int unsigned i = 0; i < 128; i++)
            access(0, 1'b1, 1'b0, 8'(i), $urandom, 1'b0, 0);
        for (int unsigned i = 0; i < 256; i++)
            access(1, 1'b1, 1'b0, 8'(i), $urandom, 1'b0, 0);

        // Directed: store/load, swap with held req, out of range, early drop.
        access(0, 1'b1, 1'b0, 8'h10, 32'h0000_00A5, 1'b0, 0);
        access(0, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 0);
        chk("load_0x10_value", mem_m[0][8'h10], 32'h0000_00A5);
        access(0, 1'b1, 1'b0, 8'h20, 32'h1111_1111, 1'b0, 0);
        access(0, 1'b0, 1'b1, 8'h20, 32'h2222_2222, 1'b0, 5);
        access(0, 1'b0, 1'b0, 8'h20, 32'h0, 1'b0, 0);
        access(0, 1'b0, 1'b0, 8'h90, 32'h0, 1'b0, 0);
        access(0, 1'b1, 1'b0, 8'h90, 32'hFFFF_FFFF, 1'b0, 0);
        access(0, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 0);
        access(0, 1'b0, 1'b0, 8'h20, 32'h0, 1'b1, 0);

        // Reset during WAIT aborts the store to 0x05.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h05, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        rst_a = 1'b0; req_a = 1'b0;
        @(posedge clk); #1;
        chk("midop_reset_ack",  {31'd0, ack_a},  32'd0);
        chk("midop_reset_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        access(0, 1'b0, 1'b0, 8'h05, 32'h0, 1'b0, 0);

        // LAT=0: load, then swp+we acting as swap, then read back.
        access(1, 1'b0, 1'b0, 8'h33, 32'h0, 1'b0, 0);
        access(1, 1'b1, 1'b1, 8'h33, 32'hCAFE_F00D, 1'b0, 3);
        access(1, 1'b0, 1'b0, 8'h33, 32'h0, 1'b0, 0);

        // Random traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            int sel;
            bit drop;
            sel  = int'($urandom_range(1, 0));
            drop = ($urandom_range(3, 0) == 0);
            access(sel, 1'($urandom), 1'($urandom_range(3, 0) == 0), 8'($urandom),
                   $urandom, drop, drop ? 0 : int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
